// File: rtl/sys1_pkg.sv
// Shared definitions for the hiscore RAM access interface: arbitration state
// encoding and the default work RAM base address.
package sys1_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } hs_state_t;

    localparam logic [15:0] RAM_BASE_DEFAULT = 16'hC000;
    localparam logic [7:0]  HSDO_BLANK       = 8'hFF;

endpackage

// File: rtl/hs_ram_port.sv
// Responder end of the hiscore RAM interface: arbitrates work RAM between CPU and hiscore engine.
// Optional macro HS_DRAIN_TIMEOUT_EN bounds the CPU drain wait to DRAIN_TIMEOUT clocks.
module hs_ram_port
    import sys1_pkg::*;
#(
    parameter int          RAM_AW        = 12,
    parameter logic [15:0] RAM_BASE      = RAM_BASE_DEFAULT,
    parameter int          DRAIN_TIMEOUT = 1023
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              hs_access,
    input  logic [15:0]       HSAD,
    input  logic [7:0]        HSDI,
    input  logic              HSWE,
    output logic [7:0]        HSDO,
    output logic              hs_grant,
    input  logic [15:0]       cpu_ad,
    input  logic [7:0]        cpu_do,
    input  logic              cpu_wr,
    input  logic              cpu_mreq,
    output logic              cpu_hold,
    output logic [RAM_AW-1:0] ram_ad,
    output logic [7:0]        ram_di,
    output logic              ram_we,
    input  logic [7:0]        ram_do
);

    // Upper window bound in 17 bits so a window touching 16'hFFFF cannot wrap.
    localparam logic [16:0] WIN_LAST = {1'b0, RAM_BASE} + (17'd1 << RAM_AW) - 17'd1;

    function automatic logic in_window(input logic [15:0] addr);
        return (addr >= RAM_BASE) && ({1'b0, addr} <= WIN_LAST);
    endfunction

    function automatic logic [RAM_AW-1:0] ram_offset(input logic [15:0] addr);
        return RAM_AW'(addr - RAM_BASE);
    endfunction

    hs_state_t state, state_nx;
    logic      cpu_in_win, hs_in_win;
    logic      drain_done;
    logic      we_mux;
    logic      rd_ok;

    assign cpu_in_win = in_window(cpu_ad);
    assign hs_in_win  = in_window(HSAD);

`ifdef HS_DRAIN_TIMEOUT_EN
    localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_TIMEOUT - 1);
    logic [9:0] drain_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            drain_cnt <= '0;
        else if (state == DRAIN)
            drain_cnt <= drain_cnt + 10'd1;
        else
            drain_cnt <= '0;
    end

    assign drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
`else
    assign drain_done = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        ram_ad   = ram_offset(cpu_ad);
        ram_di   = cpu_do;
        we_mux   = 1'b0;
        unique case (state)
            IDLE: begin
                we_mux = cpu_wr & cpu_in_win;
                if (hs_access)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                we_mux = cpu_wr & cpu_in_win;
                if (!cpu_mreq || drain_done)
                    state_nx = OWN;
            end
            OWN: begin
                ram_ad = ram_offset(HSAD);
                ram_di = HSDI;
                we_mux = HSWE & hs_in_win;
                if (!hs_access)
                    state_nx = RELEASE;
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reset blocks the write strobe combinationally so an abandoned cycle never lands.
    assign ram_we = we_mux & reset_n;

    // NOTE: state and its registered decodes use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
            hs_grant <= 1'b0;
        end else begin
            state    <= state_nx;
            cpu_hold <= (state_nx != IDLE);
            hs_grant <= (state_nx == OWN);
        end
    end

    // Read path: address captured by the RAM on edge 1, HSDO registered on edge 2.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ok <= 1'b0;
            HSDO  <= HSDO_BLANK;
        end else begin
            rd_ok <= (state == OWN) && hs_in_win;
            HSDO  <= rd_ok ? ram_do : HSDO_BLANK;
        end
    end

endmodule

// File: tb/tb_hs_ram_port.sv
// Self-checking bench for hs_ram_port: cycle vector table plus hand sequences for
// drain handshake, asynchronous reset in OWN and the drain timeout option.
module tb_hs_ram_port;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs_access = 1'b0;
    logic [15:0] HSAD = '0;
    logic [7:0]  HSDI = '0;
    logic        HSWE = 1'b0;
    logic [7:0]  HSDO;
    logic        hs_grant;
    logic [15:0] cpu_ad = '0;
    logic [7:0]  cpu_do = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_mreq = 1'b0;
    logic        cpu_hold;
    logic [11:0] ram_ad;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [7:0]  ram_do;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    hs_ram_port dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .hs_access(hs_access),
        .HSAD     (HSAD),
        .HSDI     (HSDI),
        .HSWE     (HSWE),
        .HSDO     (HSDO),
        .hs_grant (hs_grant),
        .cpu_ad   (cpu_ad),
        .cpu_do   (cpu_do),
        .cpu_wr   (cpu_wr),
        .cpu_mreq (cpu_mreq),
        .cpu_hold (cpu_hold),
        .ram_ad   (ram_ad),
        .ram_di   (ram_di),
        .ram_we   (ram_we),
        .ram_do   (ram_do)
    );

    // 4 KB work RAM with one-clock synchronous read (read-before-write).
    logic [7:0] mem [0:4095] = '{default: 8'h00};
    always @(posedge clk_sys) begin
        if (ram_we)
            mem[ram_ad] <= ram_di;
        ram_do <= mem[ram_ad];
    end

    typedef struct {
        logic        acc;
        logic [15:0] hsad;
        logic [7:0]  hsdi;
        logic        hswe;
        logic [15:0] cad;
        logic [7:0]  cdo;
        logic        cwr;
        logic        mreq;
        logic        hold;
        logic        grant;
        logic        we;
        logic        chk_ad;
        logic [11:0] ad;
        logic        chk_do;
        logic [7:0]  hsdo;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hs_access = v.acc;
        HSAD      = v.hsad;
        HSDI      = v.hsdi;
        HSWE      = v.hswe;
        cpu_ad    = v.cad;
        cpu_do    = v.cdo;
        cpu_wr    = v.cwr;
        cpu_mreq  = v.mreq;
    endtask

    task automatic idle_inputs();
        hs_access = 1'b0; HSAD = '0; HSDI = '0; HSWE = 1'b0;
        cpu_ad = '0; cpu_do = '0; cpu_wr = 1'b0; cpu_mreq = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;

        //           acc hsad     hsdi   hswe cad      cdo    cwr mreq hold grant we  chk ad       chk hsdo
        tbl[0]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hC005, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 8'hFF};
        tbl[1]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hB000, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 8'hFF};
        tbl[2]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hCFFF, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1, 8'hFF};
        tbl[3]  = '{1'b1, 16'hC001, 8'h99, 1'b1, 16'hC003, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h003, 1'b1, 8'hFF};
        tbl[4]  = '{1'b1, 16'hC001, 8'h99, 1'b1, 16'hC004, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 8'hFF};
        tbl[5]  = '{1'b1, 16'hC010, 8'h00, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 8'hFF};
        tbl[6]  = '{1'b1, 16'hC010, 8'h5A, 1'b1, 16'hC007, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h010, 1'b1, 8'hFF};
        tbl[7]  = '{1'b1, 16'hC010, 8'h00, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 1'b1, 8'hFF};
        tbl[8]  = '{1'b1, 16'hD000, 8'h77, 1'b1, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 16'hBFFF, 8'h77, 1'b1, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b1, 8'h5A};
        tbl[10] = '{1'b1, 16'hC000, 8'h00, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 8'hFF};
        tbl[11] = '{1'b0, 16'hCFFF, 8'hA5, 1'b1, 16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 8'hFF};
        tbl[12] = '{1'b1, 16'hC002, 8'h88, 1'b1, 16'hC008, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 16'h0000, 8'h00, 1'b0, 16'hC005, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 1'b0, 8'h00};
        tbl[14] = '{1'b1, 16'h0000, 8'h00, 1'b0, 16'hC005, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h005, 1'b1, 8'hFF};
        tbl[15] = '{1'b1, 16'h0000, 8'h00, 1'b0, 16'hC005, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h005, 1'b1, 8'hFF};
        tbl[16] = '{1'b1, 16'hCFFF, 8'h00, 1'b0, 16'hC005, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b1, 8'hFF};
        tbl[17] = '{1'b0, 16'hCFFF, 8'h00, 1'b0, 16'hC005, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b1, 8'hFF};
        tbl[18] = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hC004, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 8'hA5};
        tbl[19] = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hC004, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h004, 1'b0, 8'h00};

        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst.hold",  cpu_hold, 0);
        check("rst.grant", hs_grant, 0);
        check("rst.hsdo",  HSDO, 8'hFF);
        @(negedge clk_sys);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d.hold", i),  cpu_hold, tbl[i].hold);
            check($sformatf("v%0d.grant", i), hs_grant, tbl[i].grant);
            check($sformatf("v%0d.we", i),    ram_we,   tbl[i].we);
            if (tbl[i].chk_ad)
                check($sformatf("v%0d.ad", i), ram_ad, tbl[i].ad);
            if (tbl[i].chk_do)
                check($sformatf("v%0d.hsdo", i), HSDO, tbl[i].hsdo);
        end
        @(negedge clk_sys);
        idle_inputs();

        check("mem.005", mem[12'h005], 8'h11);
        check("mem.004", mem[12'h004], 8'h44);
        check("mem.010", mem[12'h010], 8'h5A);
        check("mem.fff", mem[12'hFFF], 8'hA5);
        check("mem.000", mem[12'h000], 8'h00);
        check("mem.001", mem[12'h001], 8'h00);
        check("mem.002", mem[12'h002], 8'h00);
        check("mem.007", mem[12'h007], 8'h00);
        check("mem.008", mem[12'h008], 8'h00);

        // Drain handshake with the CPU already idle
        @(negedge clk_sys);
        hs_access = 1'b1;
        @(posedge clk_sys); #1;
        check("hs42.e1.hold",  cpu_hold, 1);
        check("hs42.e1.grant", hs_grant, 0);
        @(posedge clk_sys); #1;
        check("hs42.e2.grant", hs_grant, 1);
        check("hs42.e2.hold",  cpu_hold, 1);

        // Asynchronous reset during an OWN write
        @(negedge clk_sys);
        HSAD = 16'hC030; HSDI = 8'hEE; HSWE = 1'b1;
        #1;
        check("rst46.pre.we", ram_we, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst46.grant", hs_grant, 0);
        check("rst46.hold",  cpu_hold, 0);
        check("rst46.we",    ram_we, 0);
        check("rst46.hsdo",  HSDO, 8'hFF);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        HSWE = 1'b0; HSAD = '0; HSDI = '0;
        hs_access = 1'b1;
        #1;
        check("rst46.mem030", mem[12'h030], 8'h00);
        check("rst37.pre.hold", cpu_hold, 0);
        @(posedge clk_sys); #1;
        check("rst37.hold", cpu_hold, 1);

        // Back to IDLE: DRAIN -> OWN -> RELEASE -> IDLE
        @(negedge clk_sys);
        hs_access = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("ret.hold", cpu_hold, 0);

        // Long CPU memory cycle during DRAIN
        @(negedge clk_sys);
        cpu_mreq = 1'b1;
        hs_access = 1'b1;
        @(posedge clk_sys); #1;
        check("to.enter.hold", cpu_hold, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(posedge clk_sys); #1;
            n++;
            if (hs_grant)
                seen = 1'b1;
        end
`ifdef HS_DRAIN_TIMEOUT_EN
        check("to.clocks", seen ? n : 0, 1023);
`else
        check("to.wait.grant", hs_grant, 0);
        check("to.wait.hold",  cpu_hold, 1);
`endif

        // Release to IDLE
        @(negedge clk_sys);
        cpu_mreq = 1'b0;
        @(posedge clk_sys); #1;
        check("rel.own.grant", hs_grant, 1);
        @(negedge clk_sys);
        hs_access = 1'b0;
        @(posedge clk_sys); #1;
        check("rel.rel.grant", hs_grant, 0);
        check("rel.rel.hold",  cpu_hold, 1);
        @(posedge clk_sys); #1;
        check("rel.idle.hold", cpu_hold, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
